// File: rtl/cache_packet_gen_pkg.sv
// Shared definitions for the cache traffic generator.
// Holds the unified cache packet field layout (positions and widths), the
// generator's pattern constants, the per-way FSM state type and helpers that
// build the deterministic address and data patterns.
package cache_packet_gen_pkg;

  localparam int BYTE_LEN_IN_BITS = 8;
  localparam int UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS = 4;

  // Packet field layout, LSB first.
  localparam int UNIFIED_CACHE_PACKET_VALID_POS      = 0;
  localparam int UNIFIED_CACHE_PACKET_IS_WRITE_POS   = 1;
  localparam int UNIFIED_CACHE_PACKET_CACHEABLE_POS  = 2;
  localparam int UNIFIED_CACHE_PACKET_TYPE_POS       = 3;
  localparam int UNIFIED_CACHE_PACKET_TYPE_LEN       = 2;
  localparam int UNIFIED_CACHE_PACKET_PORT_NUM_POS   = UNIFIED_CACHE_PACKET_TYPE_POS + UNIFIED_CACHE_PACKET_TYPE_LEN;
  localparam int UNIFIED_CACHE_PACKET_PORT_NUM_LEN   = 4;
  localparam int UNIFIED_CACHE_PACKET_DATA_LEN       = 64;
  localparam int UNIFIED_CACHE_PACKET_BYTE_MASK_POS  = UNIFIED_CACHE_PACKET_PORT_NUM_POS + UNIFIED_CACHE_PACKET_PORT_NUM_LEN;
  localparam int UNIFIED_CACHE_PACKET_BYTE_MASK_LEN  = UNIFIED_CACHE_PACKET_DATA_LEN / BYTE_LEN_IN_BITS;
  localparam int UNIFIED_CACHE_PACKET_ADDR_POS       = UNIFIED_CACHE_PACKET_BYTE_MASK_POS + UNIFIED_CACHE_PACKET_BYTE_MASK_LEN;
  localparam int UNIFIED_CACHE_PACKET_ADDR_LEN       = 32;
  localparam int UNIFIED_CACHE_PACKET_DATA_POS       = UNIFIED_CACHE_PACKET_ADDR_POS + UNIFIED_CACHE_PACKET_ADDR_LEN;
  localparam int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  = UNIFIED_CACHE_PACKET_DATA_POS + UNIFIED_CACHE_PACKET_DATA_LEN;

  // Generator pattern constants.
  localparam logic [7:0] GEN_PATTERN_BYTE    = 8'hA5;
  localparam int         GEN_ADDR_BASE_SHIFT = 12;

  typedef enum logic [2:0] {
    WAY_IDLE,
    WAY_SEND,
    WAY_WAIT_RETURN,
    WAY_NEXT,
    WAY_FINISH
  } way_state_e;

  // 32-bit pattern word {A5, way, k}.
  function automatic logic [31:0] pattern_word(input logic [7:0] way, input logic [15:0] k);
    return {GEN_PATTERN_BYTE, way, k};
  endfunction

  // Pattern word replicated across the whole data field.
  function automatic logic [UNIFIED_CACHE_PACKET_DATA_LEN-1:0] pattern_data(input logic [7:0] way,
                                                                           input logic [15:0] k);
    logic [UNIFIED_CACHE_PACKET_DATA_LEN-1:0] d;
    d = '0;
    for (int i = 0; i < UNIFIED_CACHE_PACKET_DATA_LEN / 32; i++) begin
      d[i*32 +: 32] = pattern_word(way, k);
    end
    return d;
  endfunction

  // Block-aligned address ((way+1) << 12) | (k << block offset).
  function automatic logic [UNIFIED_CACHE_PACKET_ADDR_LEN-1:0] pattern_addr(input logic [7:0] way,
                                                                           input logic [15:0] k);
    logic [31:0] base;
    logic [31:0] offs;
    base = ({24'd0, way} + 32'd1) << GEN_ADDR_BASE_SHIFT;
    offs = {16'd0, k} << UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS;
    return base | offs;
  endfunction

endpackage

// File: rtl/cache_packet_gen_way.sv
// One generator way: issues NUM_REQUEST/2 pattern writes followed by the
// matching read-backs, checks read data, and times out stalled requests.
// Ports: clk_in, reset_in (async, active-high); test_packet / test_packet_ack
// (request handshake); return_packet / return_packet_ack (return handshake);
// finished (way reached FINISH); failed (sticky mismatch/timeout flag).
module cache_packet_gen_way
  import cache_packet_gen_pkg::*;
#(
  parameter int WAY_ID           = 0,
  parameter int NUM_REQUEST      = 8,
  parameter int TIMING_OUT_CYCLE = 1000,
  parameter int PKT_W            = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
)(
  input  logic             clk_in,
  input  logic             reset_in,
  output logic [PKT_W-1:0] test_packet,
  input  logic             test_packet_ack,
  input  logic [PKT_W-1:0] return_packet,
  output logic             return_packet_ack,
  output logic             finished,
  output logic             failed
);

  localparam int HALF  = NUM_REQUEST / 2;
  localparam int IDX_W = $clog2(NUM_REQUEST + 1);
  localparam int CNT_W = $clog2(TIMING_OUT_CYCLE + 2);

  way_state_e         state_reg, state_next;
  logic [IDX_W-1:0]   req_idx_reg, req_idx_next;
  logic [CNT_W-1:0]   timer_reg, timer_next;
  logic               failed_reg, failed_next;
  logic               return_ack_reg, return_ack_next;

  logic               is_read;
  logic [15:0]        k_idx;
  logic               timed_out;
  logic               return_valid;
  logic [UNIFIED_CACHE_PACKET_DATA_LEN-1:0] return_data;
  logic [UNIFIED_CACHE_PACKET_DATA_LEN-1:0] expected_data;
  logic [UNIFIED_CACHE_PACKET_DATA_LEN-1:0] req_data;
  logic [UNIFIED_CACHE_PACKET_ADDR_LEN-1:0] req_addr;
  logic [UNIFIED_CACHE_PACKET_BYTE_MASK_LEN-1:0] req_mask;
  logic [PKT_W-1:0]   assembled_packet;
  logic               unused_return_bits;

  // Second half of the sequence reads back what the first half wrote.
  assign is_read       = (req_idx_reg >= IDX_W'(HALF));
  assign k_idx         = is_read ? 16'(req_idx_reg - IDX_W'(HALF)) : 16'(req_idx_reg);
  assign req_addr      = pattern_addr(8'(WAY_ID), k_idx);
  assign expected_data = pattern_data(8'(WAY_ID), k_idx);
  assign req_data      = is_read ? '0 : expected_data;
  assign req_mask      = is_read ? '0 : '1;
  assign timed_out     = (timer_reg >= CNT_W'(TIMING_OUT_CYCLE));
  assign return_valid  = return_packet[UNIFIED_CACHE_PACKET_VALID_POS];
  assign return_data   = return_packet[UNIFIED_CACHE_PACKET_DATA_POS +: UNIFIED_CACHE_PACKET_DATA_LEN];
  assign unused_return_bits = ^return_packet;

  packet_concat u_packet_concat (
    .addr      (req_addr),
    .data      (req_data),
    .byte_mask (req_mask),
    .port_num  (UNIFIED_CACHE_PACKET_PORT_NUM_LEN'(WAY_ID)),
    .pkt_type  ('0),
    .valid     (1'b1),
    .is_write  (~is_read),
    .cacheable (1'b1),
    .packet    (assembled_packet)
  );

  // State register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg      <= WAY_IDLE;
      req_idx_reg    <= '0;
      timer_reg      <= '0;
      failed_reg     <= 1'b0;
      return_ack_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_idx_reg    <= req_idx_next;
      timer_reg      <= timer_next;
      failed_reg     <= failed_next;
      return_ack_reg <= return_ack_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next   = state_reg;
    req_idx_next = req_idx_reg;
    timer_next   = timer_reg;
    failed_next  = failed_reg;
    // Any valid return is acked for one cycle; the low phase between pulses
    // gives the cache time to retire the packet it just presented.
    return_ack_next = return_valid && !return_ack_reg && (state_reg != WAY_FINISH);
    unique case (state_reg)
      WAY_IDLE: state_next = WAY_SEND;
      WAY_SEND: begin
        timer_next = timer_reg + CNT_W'(1);
        if (test_packet_ack) begin
          state_next = is_read ? WAY_WAIT_RETURN : WAY_NEXT;
        end else if (timed_out) begin
          failed_next = 1'b1;
          state_next  = WAY_FINISH;
        end
      end
      WAY_WAIT_RETURN: begin
        timer_next = timer_reg + CNT_W'(1);
        if (return_valid) begin
          if (return_data != expected_data) failed_next = 1'b1;
          state_next = WAY_NEXT;
        end else if (timed_out) begin
          failed_next = 1'b1;
          state_next  = WAY_FINISH;
        end
      end
      WAY_NEXT: begin
        req_idx_next = req_idx_reg + IDX_W'(1);
        state_next   = (req_idx_reg == IDX_W'(NUM_REQUEST - 1)) ? WAY_FINISH : WAY_SEND;
      end
      WAY_FINISH: state_next = WAY_FINISH;
      default:    state_next = WAY_IDLE;
    endcase
    // The timeout budget covers one whole request, ack and return together.
    if (state_next == WAY_SEND && state_reg != WAY_SEND) timer_next = '0;
  end

  // Outputs: the packet is presented only while in SEND, so it drops the
  // cycle after the ack is taken.
  always_comb begin
    test_packet       = (state_reg == WAY_SEND) ? assembled_packet : '0;
    return_packet_ack = return_ack_reg;
    finished          = (state_reg == WAY_FINISH);
    failed            = failed_reg;
  end

endmodule

// File: rtl/packet_concat.sv
// Assembles a unified cache packet from its individual fields.
// Ports: addr, data, byte_mask, port_num, pkt_type, valid, is_write,
//        cacheable (field inputs); packet (assembled packet output).
module packet_concat
  import cache_packet_gen_pkg::*;
(
  input  logic [UNIFIED_CACHE_PACKET_ADDR_LEN-1:0]      addr,
  input  logic [UNIFIED_CACHE_PACKET_DATA_LEN-1:0]      data,
  input  logic [UNIFIED_CACHE_PACKET_BYTE_MASK_LEN-1:0] byte_mask,
  input  logic [UNIFIED_CACHE_PACKET_PORT_NUM_LEN-1:0]  port_num,
  input  logic [UNIFIED_CACHE_PACKET_TYPE_LEN-1:0]      pkt_type,
  input  logic                                          valid,
  input  logic                                          is_write,
  input  logic                                          cacheable,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] packet
);

  always_comb begin
    packet = '0;
    packet[UNIFIED_CACHE_PACKET_VALID_POS]                                          = valid;
    packet[UNIFIED_CACHE_PACKET_IS_WRITE_POS]                                       = is_write;
    packet[UNIFIED_CACHE_PACKET_CACHEABLE_POS]                                      = cacheable;
    packet[UNIFIED_CACHE_PACKET_TYPE_POS +: UNIFIED_CACHE_PACKET_TYPE_LEN]           = pkt_type;
    packet[UNIFIED_CACHE_PACKET_PORT_NUM_POS +: UNIFIED_CACHE_PACKET_PORT_NUM_LEN]  = port_num;
    packet[UNIFIED_CACHE_PACKET_BYTE_MASK_POS +: UNIFIED_CACHE_PACKET_BYTE_MASK_LEN] = byte_mask;
    packet[UNIFIED_CACHE_PACKET_ADDR_POS +: UNIFIED_CACHE_PACKET_ADDR_LEN]          = addr;
    packet[UNIFIED_CACHE_PACKET_DATA_POS +: UNIFIED_CACHE_PACKET_DATA_LEN]          = data;
  end

endmodule

// File: rtl/cache_packet_gen.sv
// Multi-way self-checking traffic generator for the unified cache.
// Ports: clk_in, reset_in (async, active-high); test_packet_flatted_out /
// test_packet_ack_flatted_in (per-way requests, slice w*PKT_W); 
// return_packet_flatted_in / return_packet_ack_flatted_out (per-way returns);
// done (all ways finished, sticky); error (any way failed, sticky).
module cache_packet_gen
  import cache_packet_gen_pkg::*;
#(
  parameter int NUM_WAY          = 2,
  parameter int NUM_REQUEST      = 8,
  parameter int TIMING_OUT_CYCLE = 1000,
  parameter int PKT_W            = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
)(
  input  logic                     clk_in,
  input  logic                     reset_in,
  output logic [NUM_WAY*PKT_W-1:0] test_packet_flatted_out,
  input  logic [NUM_WAY-1:0]       test_packet_ack_flatted_in,
  input  logic [NUM_WAY*PKT_W-1:0] return_packet_flatted_in,
  output logic [NUM_WAY-1:0]       return_packet_ack_flatted_out,
  output logic                     done,
  output logic                     error
);

  logic [NUM_WAY-1:0] finished;
  logic [NUM_WAY-1:0] failed;
  logic               done_reg;

  generate
    for (genvar gi = 0; gi < NUM_WAY; gi++) begin : g_way
      cache_packet_gen_way #(
        .WAY_ID           (gi),
        .NUM_REQUEST      (NUM_REQUEST),
        .TIMING_OUT_CYCLE (TIMING_OUT_CYCLE),
        .PKT_W            (PKT_W)
      ) u_way (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .test_packet       (test_packet_flatted_out[gi*PKT_W +: PKT_W]),
        .test_packet_ack   (test_packet_ack_flatted_in[gi]),
        .return_packet     (return_packet_flatted_in[gi*PKT_W +: PKT_W]),
        .return_packet_ack (return_packet_ack_flatted_out[gi]),
        .finished          (finished[gi]),
        .failed            (failed[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) done_reg <= 1'b0;
    else          done_reg <= done_reg | (&finished);
  end

  assign done  = done_reg;
  assign error = |failed;

endmodule

// File: tb/tb_cache_packet_gen.sv
module tb_cache_packet_gen;
  import cache_packet_gen_pkg::*;

  localparam int NW = 2;
  localparam int NR = 8;
  localparam int TO = 20;
  localparam int PW = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int DL = UNIFIED_CACHE_PACKET_DATA_LEN;
  localparam int AP = UNIFIED_CACHE_PACKET_ADDR_POS;
  localparam int DP = UNIFIED_CACHE_PACKET_DATA_POS;
  localparam int VP = UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int WP = UNIFIED_CACHE_PACKET_IS_WRITE_POS;

  logic             clk_in   = 1'b0;
  logic             reset_in = 1'b1;
  logic [NW*PW-1:0] req_flat;
  logic [NW-1:0]    req_ack  = '0;
  logic [NW*PW-1:0] ret_flat = '0;
  logic [NW-1:0]    ret_ack;
  logic             done;
  logic             error;

  int total = 0;
  int bad   = 0;

  int            ack_delay [NW];
  logic [NW-1:0] never_ack = '0;
  logic          corrupt   = 1'b0;

  int             wait_cnt [NW];
  int             ret_cnt  [NW];
  int             accepted [NW];
  int             ret_seen [NW];
  int             run_len  [NW];
  int             max_run  [NW];
  int             pulses   [NW];
  logic [PW-1:0]  ret_pkt  [NW];
  logic [DL-1:0]  mem [logic [31:0]];
  logic [PW-1:0]  p, rp, snap;
  logic [31:0]    a;

  cache_packet_gen #(
    .NUM_WAY(NW), .NUM_REQUEST(NR), .TIMING_OUT_CYCLE(TO), .PKT_W(PW)
  ) dut (
    .clk_in                        (clk_in),
    .reset_in                      (reset_in),
    .test_packet_flatted_out       (req_flat),
    .test_packet_ack_flatted_in    (req_ack),
    .return_packet_flatted_in      (ret_flat),
    .return_packet_ack_flatted_out (ret_ack),
    .done                          (done),
    .error                         (error)
  );

  always #5 clk_in = ~clk_in;

  // Cache responder: acks requests after ack_delay cycles, stores writes and
  // returns stored data two cycles after a read is accepted.
  always @(negedge clk_in) begin
    for (int w = 0; w < NW; w++) begin
      p = req_flat[w*PW +: PW];
      if (reset_in) begin
        req_ack[w] = 1'b0;
        ret_flat[w*PW +: PW] = '0;
        wait_cnt[w] = 0; ret_cnt[w] = 0; accepted[w] = 0; ret_seen[w] = 0;
        run_len[w] = 0; max_run[w] = 0; pulses[w] = 0;
      end else begin
        if (ret_ack[w]) run_len[w]++;
        else if (run_len[w] > 0) begin
          if (run_len[w] > max_run[w]) max_run[w] = run_len[w];
          pulses[w]++;
          run_len[w] = 0;
        end
        if (ret_flat[w*PW + VP] && ret_ack[w]) begin
          ret_flat[w*PW +: PW] = '0;
          ret_seen[w]++;
        end
        if (ret_cnt[w] != 0) begin
          ret_cnt[w]--;
          if (ret_cnt[w] == 0) ret_flat[w*PW +: PW] = ret_pkt[w];
        end
        if (req_ack[w]) begin
          req_ack[w] = 1'b0;
          wait_cnt[w] = 0;
        end else if (p[VP] && !never_ack[w]) begin
          if (wait_cnt[w] >= ack_delay[w]) begin
            req_ack[w] = 1'b1;
            accepted[w]++;
            a = p[AP +: 32];
            if (p[WP]) begin
              mem[a] = p[DP +: DL];
              $display("way %0d write addr=%h data=%h", w, a, p[DP +: DL]);
            end else begin
              rp = '0;
              rp[VP] = 1'b1;
              rp[DP +: DL] = mem.exists(a) ? mem[a] : '0;
              if (corrupt && w == 1 && a == 32'h2020) rp[DP] = ~rp[DP];
              ret_pkt[w] = rp;
              ret_cnt[w] = 2;
              $display("way %0d read  addr=%h return=%h", w, a, rp[DP +: DL]);
            end
          end else begin
            wait_cnt[w]++;
          end
        end else begin
          wait_cnt[w] = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk_in);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic restart(input int d, input logic [NW-1:0] na, input logic c);
    @(negedge clk_in);
    reset_in = 1'b1;
    ack_delay[0] = d; ack_delay[1] = d;
    never_ack = na;
    corrupt = c;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ack_delay[0] = 0; ack_delay[1] = 0;

    // Reset state and first request.
    repeat (10) @(negedge clk_in);
    check("rst_req", req_flat, 0);
    check("rst_ret_ack", ret_ack, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset_in = 1'b0;
    @(negedge clk_in);
    check("first_valid", req_flat[VP], 1);
    check("first_addr", req_flat[AP +: 32], 32'h1000);
    check("first_wr", req_flat[WP], 1);
    check("first_mask", req_flat[UNIFIED_CACHE_PACKET_BYTE_MASK_POS +: 8], 8'hFF);
    check("first_data", req_flat[DP +: DL], 64'hA5000000_A5000000);
    check("first_cacheable", req_flat[UNIFIED_CACHE_PACKET_CACHEABLE_POS], 1);
    check("w1_port", req_flat[PW + UNIFIED_CACHE_PACKET_PORT_NUM_POS +: 4], 4'd1);
    check("w1_addr", req_flat[PW + AP +: 32], 32'h2000);

    // Ideal responder run.
    wait_done(300, "ideal_done");
    check("ideal_error", error, 0);
    check("ideal_acc_w0", accepted[0], 8);
    check("ideal_acc_w1", accepted[1], 8);
    check("ideal_ret_w0", ret_seen[0], 4);
    check("ideal_ret_w1", ret_seen[1], 4);
    check("w1_k0_word", mem[32'h2000][31:0], 32'hA5010000);
    check("w0_k3_word", mem[32'h1030][63:32], 32'hA5000003);
    check("w1_k1_addr_data", mem[32'h2010], 64'hA5010001_A5010001);
    check("idle_req", req_flat, 0);

    // Corrupted read 2 on way 1.
    restart(0, '0, 1'b1);
    @(negedge clk_in);
    check("corr_err_early", error, 0);
    wait_done(300, "corr_done");
    check("corr_error", error, 1);
    repeat (5) @(negedge clk_in);
    check("corr_err_sticky", error, 1);
    check("corr_done_sticky", done, 1);
    @(posedge clk_in);
    #3 reset_in = 1'b1;
    #1;
    check("async_rst_error", error, 0);
    check("async_rst_done", done, 0);

    // Way 0 never acked: timeout.
    restart(0, 2'b01, 1'b0);
    repeat (TO + 1) @(negedge clk_in);
    check("to_not_yet", error, 0);
    @(negedge clk_in);
    check("to_error", error, 1);
    wait_done(300, "to_done");
    check("to_error_hold", error, 1);
    check("to_acc_w0", accepted[0], 0);
    check("to_acc_w1", accepted[1], 8);
    check("to_w0_quiet", req_flat[0 +: PW], 0);

    // Reset mid-sequence restarts from request 0.
    restart(0, '0, 1'b0);
    repeat (6) @(negedge clk_in);
    reset_in = 1'b1;
    #1;
    check("mid_rst_req", req_flat, 0);
    check("mid_rst_ret_ack", ret_ack, 0);
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    @(negedge clk_in);
    check("mid_restart_addr", req_flat[AP +: 32], 32'h1000);
    check("mid_restart_wr", req_flat[WP], 1);
    wait_done(300, "mid_done");
    check("mid_error", error, 0);

    // Ack delayed by 5 cycles.
    restart(5, '0, 1'b0);
    @(negedge clk_in);
    snap = req_flat[0 +: PW];
    check("dly_addr", snap[AP +: 32], 32'h1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("dly_hold", req_flat[0 +: PW], snap);
    end
    @(negedge clk_in);
    check("dly_drop", req_flat[0 +: PW], 0);
    wait_done(600, "dly_done");
    check("dly_error", error, 0);
    check("dly_pulse_w0", max_run[0], 1);
    check("dly_pulse_w1", max_run[1], 1);
    check("dly_pulses_w0", pulses[0], 4);
    check("dly_pulses_w1", pulses[1], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_packet_gen.md
Name: cache_packet_gen

Overview:
- Self-checking traffic generator for verifying unified_cache.
- Drives NUM_WAY independent request ports with a deterministic write-then-read-back sequence and checks the returned read data.
- Flags completion (done) and any failure (error): data mismatch or timeout.
- Sits in unit-test benches between the bench and the cache's input/return packet ports; it is not synthesised into the core.

Parameters:
- NUM_WAY, 2, number of cache input ports driven in parallel.
- NUM_REQUEST, 8, requests per way; must be even and at least 2.
- TIMING_OUT_CYCLE, 1000, maximum cycles a request may wait for ack or return.
- PKT_W, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, packet width.

Ports:
- clk_in  in  1  clock.
- reset_in  in  1  reset; asynchronous, active-high.
- test_packet_flatted_out  out  NUM_WAY*PKT_W  request packets; way w occupies slice [w*PKT_W +: PKT_W].
- test_packet_ack_flatted_in  in  NUM_WAY  cache accepted way w's request.
- return_packet_flatted_in  in  NUM_WAY*PKT_W  cache return packets, same slicing.
- return_packet_ack_flatted_out  out  NUM_WAY  generator consumed way w's return.
- done  out  1  all ways finished (passed or failed).
- error  out  1  sticky failure flag.

Behaviour:
- One clock; reset is asynchronous and active-high (clk_in, reset_in). Every register clears on reset_in, including when asserted mid-sequence; the sequence restarts from request 0 after release.
- Reset values: all packets 0, acks 0, done 0, error 0.
- Sequence per way w, with H = NUM_REQUEST/2 and request index i:
  - i < H: write. Address A(w,k) = ((w+1) << 12) | (k << `UNIFIED_CACHE_BLOCK_OFFSET_LEN_IN_BITS), with k = i.
  - Write data D(w,k) = the 32-bit word {8'hA5, w[7:0], k[15:0]} replicated across the data field.
  - Write byte mask all ones; is_write = 1.
  - i >= H: read of A(w, i-H); is_write = 0, mask 0, data 0; expected data D(w, i-H).
- Common packet fields: valid = 1, cacheable = 1, port_num = w, type = 0.
- Packet assembly uses the packet_concat field layout (`UNIFIED_CACHE_PACKET_*_POS macros).
- Per-way FSM states: SEND, WAIT_RETURN, NEXT, FINISH.
  - After reset release, every way enters SEND on the first clock edge.
  - SEND: drive the packet. It must stay stable until test_packet_ack[w] is sampled 1. On ack, the packet goes to 0 next cycle. Writes then go to NEXT; reads go to WAIT_RETURN.
  - WAIT_RETURN: when return valid[w] is sampled 1, assert return_packet_ack[w] for exactly one cycle (registered). Compare the returned data field with the expected value; a mismatch sets error. Go to NEXT.
  - NEXT: i++. If i == NUM_REQUEST go to FINISH, else go to SEND.
  - FINISH: hold all outputs of that way at 0; the way's finished flag is 1.
- Valid return packets arriving outside WAIT_RETURN (e.g. write responses) are acked for one cycle and ignored; they are never checked.
- Timeout: a per-way counter clears on entering SEND and increments every cycle in SEND or WAIT_RETURN. When it exceeds TIMING_OUT_CYCLE, error is set and the way goes to FINISH.
- done = AND of the per-way finished flags, registered; once set it stays 1 until reset.
- error = OR of all per-way failures; sticky.
- Ways are fully independent; simultaneous acks or returns on several ways are handled in the same cycle.

Decomposition:
- Packet field positions and widths come from the existing shared parameters header/package (`UNIFIED_CACHE_PACKET_*`, BYTE_LEN_IN_BITS).
- Add constants there for the pattern byte 8'hA5 and the address base shift 12.
- Sub-module cache_packet_gen_way: one way's FSM, counters and checker, parameterised by WAY_ID. The top instantiates it NUM_WAY times via generate and reduces done/error.
- packet_concat is reused for packet assembly.

Test Plan:
- Reset: hold reset_in 10 cycles -> all packets 0, acks 0, done 0, error 0; deassert reset -> way 0 packet valid next edge with addr 0x1000, is_write 1.
- Ideal responder: ack same cycle, return stored data 2 cycles later for reads -> done=1, error=0 after the 8th request on both ways; read 0 of way 1 expects data word 0xA5010000.
- Corrupt one returned data bit on way 1, read 2 -> error=1 sticky, done still reaches 1.
- Never ack way 0 -> error=1 at cycle TIMING_OUT_CYCLE+1 after SEND entry; way 1 completes normally; done=1.
- Ack delayed 5 cycles -> packet held stable for all 5 cycles; the return ack pulse is exactly 1 cycle wide.
- Full system with unified_cache (2 ports) and a memory model with 10-cycle delay -> done=1 and error=0 within NUM_REQUEST*TIMING_OUT_CYCLE*2 cycles.
